wb_regfile: RTL
===============

# wb_regfile

Architectural register file and commit tracker for the miniLA pipeline; the consumer end of the MEM/WB stage register. It takes the MEM/WB write-back bundle (`wb_ena`, `wb_reg`, `wb_value`, `have_inst`, `pc`, `inst`), commits writes to the 32×32 general register file, and serves two ID-stage read ports with same-cycle write-through bypass. It also keeps a retired-instruction counter and a registered commit trace for on-board debug.

## Interface
Parameters:
- `DATA_W`, 32, register and data width.
- `REG_NUM`, 32, number of architectural registers.
- `ADDR_W`, 5, register index width; `REG_NUM` equals 2^`ADDR_W`.

Ports:
- `clk`  input  1  system clock. All state updates occur on its rising edge.
- `rst_n`  input  1  reset. Asynchronous, active-low.
- `wb_ena`  input  1  write enable from MEM/WB.
- `wb_reg`  input  `ADDR_W`  destination register index.
- `wb_value`  input  `DATA_W`  write-back data.
- `have_inst`  input  1  MEM/WB slot holds a valid (non-bubble) instruction.
- `wb_pc`  input  32  PC of the committing instruction.
- `wb_inst`  input  32  raw encoding of the committing instruction.
- `ra1`, `ra2`  input  `ADDR_W`  ID-stage read addresses.
- `rd1`, `rd2`  output  `DATA_W`  read data, combinational.
- `commit_cnt`  output  32  number of retired instructions.
- `trace_valid`  output  1  one-cycle pulse; the trace fields are valid.
- `trace_pc`, `trace_inst`  output  32  PC and encoding of the last commit.
- `trace_wen`  output  1  that commit wrote a register.
- `trace_reg`  output  `ADDR_W`  destination index of that commit.
- `trace_value`  output  `DATA_W`  value written by that commit.

## Operation
- Storage is `REG_NUM` words. Register 0 is hardwired to zero: writes to it are discarded and reads of it return 0.
- Effective write condition: `we = wb_ena & have_inst & (wb_reg != 0)`. A bubble never writes, even when `wb_ena` is high.
- When `we` is true, `wb_value` is stored at `wb_reg` on the rising edge of `clk`.
- Read path for each port, independently:
  - `ra == 0` returns 0.
  - Otherwise, if `we` is true and `ra == wb_reg`, the port returns `wb_value` (bypass).
  - Otherwise the port returns the stored word.
- `ra1 == ra2` is legal; both ports return identical data.
- `commit_cnt` increments by 1 on each cycle with `have_inst = 1`. It wraps from 0xFFFF_FFFF to 0 with no flag.
- Trace registers are loaded on each cycle with `have_inst = 1`:
  - `trace_pc <= wb_pc`, `trace_inst <= wb_inst`.
  - `trace_wen <= we`, `trace_reg <= wb_reg`.
  - `trace_value <= we ? wb_value : 0`.
- `trace_valid <= have_inst` every cycle. On cycles without a commit, the other trace fields hold their last values.

## Timing
- Read latency is 0 cycles: `rd1`/`rd2` are combinational in `ra*`, the storage, and the write-back inputs.
- A write is visible through storage from the cycle after the edge that stores it. In the same cycle it is visible through the bypass.
- Trace and counter outputs have 1-cycle latency after the commit edge.
- Reset (`rst_n` low, asynchronous, valid mid-operation):
  - All storage is cleared to 0.
  - `commit_cnt = 0`, `trace_valid = 0`.
  - All trace fields are 0.
  - With `ra*` held, `rd1`/`rd2` return 0 immediately.
- Deassertion of `rst_n` is synchronous to `clk` externally. The first commit can occur on the first edge after deassertion.

## Structure
- Shared package `la_pkg` holds:
  - `REG_ZERO = 5'd0`.
  - The width constants `DATA_W` and `ADDR_W`.
  - A `wb_bundle_t` grouping `wb_ena`/`wb_reg`/`wb_value`/`have_inst`/`wb_pc`/`wb_inst`, so MEM/WB and this block share one definition.
- One sub-module, `gpr_array`, holds storage plus the two combinational read ports (no bypass). Bypass, zero masking, the counter and the trace live in `wb_regfile`.

## Test plan
- Reset: drive `rst_n` low mid-run after writing r5 = 0x1234. Expect `rd1` for `ra1 = 5` to return 0 immediately; `commit_cnt = 0`; `trace_valid = 0`.
- Write then read:
  - Commit `wb_reg = 3`, `wb_value = 0xDEADBEEF`, `have_inst = 1`.
  - In the same cycle, `ra1 = 3` returns 0xDEADBEEF (bypass).
  - Next cycle, with write-back idle, it still returns 0xDEADBEEF (storage).
- r0 protection: commit `wb_reg = 0`, `wb_value = 0xFFFFFFFF`. Expect `rd1(0) = 0` both in the same cycle and afterward; `trace_wen = 0`; `trace_value = 0`.
- Bubble: `wb_ena = 1`, `have_inst = 0`, `wb_reg = 7`, `wb_value = 0x55`. Expect r7 unchanged, `commit_cnt` unchanged, `trace_valid = 0` next cycle.
- Dual-port conflict: set `ra1 = ra2 = 9` while committing r9 = 0xA5A5A5A5. Both ports return 0xA5A5A5A5. A different address, r10 = 0x10 (written earlier), returns 0x10.
- Counter wrap: force `commit_cnt` to 0xFFFFFFFE, then apply 3 commits. Expect 0xFFFFFFFF, 0x0, 0x1. `trace_pc` tracks each `wb_pc` with 1-cycle lag.

Source files
------------

// File: rtl/la_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// la_pkg : shared miniLA widths, constants and the MEM/WB write-back bundle
// rev 1.0
// ---------------------------------------------------------------------------
package la_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int REG_NUM = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              wb_ena;
    logic [ADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0] wb_value;
    logic              have_inst;
    logic [31:0]       wb_pc;
    logic [31:0]       wb_inst;
  } wb_bundle_t;

endpackage
`default_nettype wire

// File: rtl/wb_regfile_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_regfile_if : MEM/WB write-back, ID read ports and commit trace signals
// rev 1.0
// ---------------------------------------------------------------------------
interface wb_regfile_if #(
  parameter int DATA_W = la_pkg::DATA_W,
  parameter int ADDR_W = la_pkg::ADDR_W
);
  logic              wb_ena;
  logic [ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_value;
  logic              have_inst;
  logic [31:0]       wb_pc;
  logic [31:0]       wb_inst;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [31:0]       commit_cnt;
  logic              trace_valid;
  logic [31:0]       trace_pc;
  logic [31:0]       trace_inst;
  logic              trace_wen;
  logic [ADDR_W-1:0] trace_reg;
  logic [DATA_W-1:0] trace_value;

  modport master (
    output wb_ena, wb_reg, wb_value, have_inst, wb_pc, wb_inst, ra1, ra2,
    input  rd1, rd2, commit_cnt, trace_valid, trace_pc, trace_inst,
           trace_wen, trace_reg, trace_value
  );

  modport slave (
    input  wb_ena, wb_reg, wb_value, have_inst, wb_pc, wb_inst, ra1, ra2,
    output rd1, rd2, commit_cnt, trace_valid, trace_pc, trace_inst,
           trace_wen, trace_reg, trace_value
  );
endinterface
`default_nettype wire

// File: rtl/wb_regfile_gpr_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gpr_array : general register storage with two raw combinational read ports
// rev 1.0
// ---------------------------------------------------------------------------
module gpr_array #(
  parameter int DATA_W  = la_pkg::DATA_W,
  parameter int ADDR_W  = la_pkg::ADDR_W,
  parameter int REG_NUM = la_pkg::REG_NUM
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] wa,
  input  wire logic [DATA_W-1:0] wd,
  input  wire logic [ADDR_W-1:0] ra1,
  input  wire logic [ADDR_W-1:0] ra2,
  output logic      [DATA_W-1:0] rd1,
  output logic      [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] r_mem [REG_NUM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[wa] <= wd;
    end
  end

  assign rd1 = r_mem[ra1];
  assign rd2 = r_mem[ra2];

endmodule
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_regfile : register file commit stage with write-through bypass, retired
//              instruction counter and registered commit trace. rev 1.0
// ---------------------------------------------------------------------------
module wb_regfile
  import la_pkg::*;
#(
  parameter int DATA_W  = la_pkg::DATA_W,
  parameter int REG_NUM = la_pkg::REG_NUM,
  parameter int ADDR_W  = la_pkg::ADDR_W
) (
  input wire logic   clk,
  input wire logic   rst_n,
  wb_regfile_if.slave bus
);

  wb_bundle_t        w_wb;
  logic              w_we;
  logic [DATA_W-1:0] w_rd1_raw;
  logic [DATA_W-1:0] w_rd2_raw;

  logic [31:0]       r_commit_cnt;
  logic              r_trace_valid;
  logic [31:0]       r_trace_pc;
  logic [31:0]       r_trace_inst;
  logic              r_trace_wen;
  logic [ADDR_W-1:0] r_trace_reg;
  logic [DATA_W-1:0] r_trace_value;

  assign w_wb = '{wb_ena:    bus.wb_ena,
                  wb_reg:    bus.wb_reg,
                  wb_value:  bus.wb_value,
                  have_inst: bus.have_inst,
                  wb_pc:     bus.wb_pc,
                  wb_inst:   bus.wb_inst};

  // A bubble must never write, and r0 stays zero by never being written.
  assign w_we = w_wb.wb_ena & w_wb.have_inst & (w_wb.wb_reg != REG_ZERO);

  gpr_array #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .REG_NUM (REG_NUM)
  ) u_gpr (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_we),
    .wa    (w_wb.wb_reg),
    .wd    (w_wb.wb_value),
    .ra1   (bus.ra1),
    .ra2   (bus.ra2),
    .rd1   (w_rd1_raw),
    .rd2   (w_rd2_raw)
  );

  function automatic logic [DATA_W-1:0] port_read(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] raw,
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    if (ra == REG_ZERO)       return '0;
    else if (we && ra == wa)  return wd;
    else                      return raw;
  endfunction

  assign bus.rd1 = port_read(bus.ra1, w_rd1_raw, w_we, w_wb.wb_reg, w_wb.wb_value);
  assign bus.rd2 = port_read(bus.ra2, w_rd2_raw, w_we, w_wb.wb_reg, w_wb.wb_value);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_commit_cnt  <= '0;
      r_trace_valid <= 1'b0;
      r_trace_pc    <= '0;
      r_trace_inst  <= '0;
      r_trace_wen   <= 1'b0;
      r_trace_reg   <= '0;
      r_trace_value <= '0;
    end else begin
      r_trace_valid <= w_wb.have_inst;
      if (w_wb.have_inst) begin
        r_commit_cnt  <= r_commit_cnt + 32'd1;
        r_trace_pc    <= w_wb.wb_pc;
        r_trace_inst  <= w_wb.wb_inst;
        r_trace_wen   <= w_we;
        r_trace_reg   <= w_wb.wb_reg;
        r_trace_value <= w_we ? w_wb.wb_value : '0;
      end
    end
  end

  assign bus.commit_cnt  = r_commit_cnt;
  assign bus.trace_valid = r_trace_valid;
  assign bus.trace_pc    = r_trace_pc;
  assign bus.trace_inst  = r_trace_inst;
  assign bus.trace_wen   = r_trace_wen;
  assign bus.trace_reg   = r_trace_reg;
  assign bus.trace_value = r_trace_value;

endmodule
`default_nettype wire
